// File: rtl/audio_pkg.sv
// Shared definitions for the audio codec capture path: FSM state encoding,
// default sample width and I2S channel-select values.
package audio_pkg;

    localparam int AUDIO_SAMPLE_WIDTH = 16;

    localparam logic LEFT_SLOT  = 1'b0;
    localparam logic RIGHT_SLOT = 1'b1;

    typedef enum logic [1:0] {
        ST_ALIGN = 2'd0,
        ST_LEFT  = 2'd1,
        ST_RIGHT = 2'd2
    } audio_state_e;

endpackage

// File: rtl/audio_sync_edge.sv
// N-stage synchronizer for an asynchronous level input, producing a registered
// one-cycle pulse on each rising edge of the synchronized level.
module audio_sync_edge
    import audio_pkg::*;
#(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic rise
);

    logic [STAGES-1:0] sync_q;
    logic              prev_q;

    // Shift the pin through the synchronizer and flag 0->1 transitions.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q <= '0;
            prev_q <= 1'b0;
            rise   <= 1'b0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d};
            prev_q <= sync_q[STAGES-1];
            rise   <= sync_q[STAGES-1] & ~prev_q;
        end
    end

endmodule

// File: rtl/audio_adc_receiver.sv
// I2S ADC capture: oversamples bclk/adclrc/adcdat on clk, deserialises
// left/right words MSB-first and publishes stereo pairs on valid/ready.
// Optional sticky overrun flag built when AUDIO_RX_OVERRUN_EN is defined.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ALIGN    | discarding bits until a right->left word end is seen
// LEFT     | shifting in the left word
// RIGHT    | shifting in the right word; its end publishes the pair
module audio_adc_receiver
    import audio_pkg::*;
#(
    parameter int SAMPLE_WIDTH = AUDIO_SAMPLE_WIDTH,
    parameter int SYNC_STAGES  = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    bclk,
    input  logic                    adclrc,
    input  logic                    adcdat,
    output logic [SAMPLE_WIDTH-1:0] data_left,
    output logic [SAMPLE_WIDTH-1:0] data_right,
    output logic                    valid,
    input  logic                    ready,
    output logic                    overrun
);

    localparam int                CNT_W   = $clog2(SAMPLE_WIDTH + 1);
    localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(SAMPLE_WIDTH);

    logic                    bit_evt;
    logic [SYNC_STAGES-1:0]  lrc_sync_q;
    logic [SYNC_STAGES-1:0]  dat_sync_q;
    logic                    l_k;
    logic                    d_k;

    audio_state_e            state_q;
    logic                    seen_q;
    logic                    l_prev_q;
    logic [SAMPLE_WIDTH-1:0] shift_q;
    logic [CNT_W-1:0]        bit_cnt_q;
    logic [SAMPLE_WIDTH-1:0] hold_left_q;

    logic [SAMPLE_WIDTH-1:0] shift_ins;
    logic                    active;
    logic                    word_end;
    logic                    publish;
    logic                    latch_left;
    logic                    align;

    audio_sync_edge #(.STAGES(SYNC_STAGES)) u_bclk_sync (
        .clk   (clk),
        .reset (reset),
        .d     (bclk),
        .rise  (bit_evt)
    );

    // Word select and data share the bclk synchronizer depth so all three stay aligned.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lrc_sync_q <= '0;
            dat_sync_q <= '0;
        end else begin
            lrc_sync_q <= {lrc_sync_q[SYNC_STAGES-2:0], adclrc};
            dat_sync_q <= {dat_sync_q[SYNC_STAGES-2:0], adcdat};
        end
    end

    assign l_k = lrc_sync_q[SYNC_STAGES-1];
    assign d_k = dat_sync_q[SYNC_STAGES-1];

    // Place the current bit at its MSB-first position and decode word boundaries.
    always_comb begin
        shift_ins = shift_q;
        for (int i = 0; i < SAMPLE_WIDTH; i++) begin
            if (int'(bit_cnt_q) == SAMPLE_WIDTH - 1 - i) begin
                shift_ins[i] = d_k;
            end
        end
        active     = bit_evt && seen_q;
        word_end   = (l_k != l_prev_q);
        publish    = active && (state_q == ST_RIGHT) && word_end && (l_prev_q == RIGHT_SLOT);
        latch_left = active && (state_q == ST_LEFT) && word_end && (l_prev_q == LEFT_SLOT);
        align      = active && (state_q == ST_ALIGN) && word_end &&
                     (l_prev_q == RIGHT_SLOT) && (l_k == LEFT_SLOT);
    end

    // Capture FSM: shift register, saturating bit counter and left holding register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_ALIGN;
            seen_q      <= 1'b0;
            l_prev_q    <= 1'b0;
            shift_q     <= '0;
            bit_cnt_q   <= '0;
            hold_left_q <= '0;
        end else if (bit_evt) begin
            seen_q   <= 1'b1;
            l_prev_q <= l_k;
            if (seen_q) begin
                case (state_q)
                    ST_ALIGN: begin
                        if (align) begin
                            state_q   <= ST_LEFT;
                            shift_q   <= '0;
                            bit_cnt_q <= '0;
                        end
                    end
                    ST_LEFT, ST_RIGHT: begin
                        if (word_end) begin
                            shift_q   <= '0;
                            bit_cnt_q <= '0;
                            if (latch_left) begin
                                hold_left_q <= shift_ins;
                                state_q     <= ST_RIGHT;
                            end else if (publish) begin
                                state_q <= ST_LEFT;
                            end else begin
                                // Word select disagrees with the slot we expected: resync.
                                state_q <= ST_ALIGN;
                            end
                        end else begin
                            shift_q <= shift_ins;
                            if (bit_cnt_q != CNT_MAX) begin
                                bit_cnt_q <= bit_cnt_q + CNT_W'(1);
                            end
                        end
                    end
                    default: state_q <= ST_ALIGN;
                endcase
            end
        end
    end

    // Output pair and valid; a publish wins over a same-cycle accept.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_left  <= '0;
            data_right <= '0;
            valid      <= 1'b0;
        end else if (publish) begin
            data_left  <= hold_left_q;
            data_right <= shift_ins;
            valid      <= 1'b1;
        end else if (valid && ready) begin
            valid <= 1'b0;
        end
    end

`ifdef AUDIO_RX_OVERRUN_EN
    logic overrun_q;

    // Sticky flag: a pair was replaced before the sink took it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overrun_q <= 1'b0;
        end else if (publish && valid && !ready) begin
            overrun_q <= 1'b1;
        end
    end

    assign overrun = overrun_q;
`else
    assign overrun = 1'b0;
`endif

endmodule

// File: tb/tb_audio_adc_receiver.sv
// Self-checking bench for audio_adc_receiver: a table of frames checked through
// a scoreboard queue, plus hand sequences for handshake, overrun, reset and
// same-cycle publish/accept.
module tb_audio_adc_receiver;

`ifdef AUDIO_RX_OVERRUN_EN
    localparam logic EXP_OVR = 1'b1;
`else
    localparam logic EXP_OVR = 1'b0;
`endif

    logic        clk;
    logic        reset;
    logic        bclk;
    logic        adclrc;
    logic        adcdat;
    logic [15:0] data_left;
    logic [15:0] data_right;
    logic        valid;
    logic        ready;
    logic        overrun;

    audio_adc_receiver #(.SAMPLE_WIDTH(16), .SYNC_STAGES(2)) dut (
        .clk        (clk),
        .reset      (reset),
        .bclk       (bclk),
        .adclrc     (adclrc),
        .adcdat     (adcdat),
        .data_left  (data_left),
        .data_right (data_right),
        .valid      (valid),
        .ready      (ready),
        .overrun    (overrun)
    );

    typedef struct {
        int          n;
        logic [31:0] l;
        logic [31:0] r;
        logic [15:0] el;
        logic [15:0] er;
    } vec_t;

    typedef struct {
        logic [15:0] l;
        logic [15:0] r;
    } pair_t;

    vec_t  tbl[6];
    pair_t sb[$];
    int    n_pass  = 0;
    int    n_total = 0;
    logic  pend;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    endtask

    // One bclk slot: low phase with word select and data set, then the rising edge.
    task automatic slot_rise(input logic l, input logic d);
        @(posedge clk); #1;
        bclk = 1'b0; adclrc = l; adcdat = d;
        repeat (4) @(posedge clk);
        #1 bclk = 1'b1;
    endtask

    task automatic send_slot(input logic l, input logic d);
        slot_rise(l, d);
        repeat (3) @(posedge clk);
    endtask

    // Data lags word select by one slot (I2S), carried in pend.
    task automatic send_word(input logic l, input logic [31:0] w, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            send_slot(l, pend);
            pend = w[i];
        end
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        reset = 1'b1; ready = 1'b0; bclk = 1'b0; adclrc = 1'b1; adcdat = 1'b0; pend = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    // Scoreboard: every accepted pair must match the oldest expected pair.
    always @(negedge clk) begin
        if (!reset && valid && ready) begin
            if (sb.size() == 0) begin
                n_total++;
                $display("FAIL unexpected_pair: got %h/%h expected none", data_left, data_right);
            end else begin
                pair_t p;
                p = sb.pop_front();
                chk("pair_left", {16'h0, data_left}, {16'h0, p.l});
                chk("pair_right", {16'h0, data_right}, {16'h0, p.r});
            end
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout expected completion");
        $display("%0d/%0d checks passed", n_pass, n_total);
        $fatal(1, "timeout");
    end

    initial begin
        logic [15:0] w;
        tbl[0] = '{16, 32'h0000A5C3, 32'h00000F01, 16'hA5C3, 16'h0F01};
        tbl[1] = '{16, 32'h0000FFFF, 32'h00000000, 16'hFFFF, 16'h0000};
        tbl[2] = '{24, 32'h00800001, 32'h00123456, 16'h8000, 16'h1234};
        tbl[3] = '{12, 32'h00000FFF, 32'h000005A5, 16'hFFF0, 16'h5A50};
        tbl[4] = '{17, 32'h0001FFFF, 32'h00000001, 16'hFFFF, 16'h0000};
        tbl[5] = '{16, 32'h00001234, 32'h00005678, 16'h1234, 16'h5678};

        reset = 1'b1; ready = 1'b0; bclk = 1'b0; adclrc = 1'b1; adcdat = 1'b0; pend = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_left", {16'h0, data_left}, 32'h0);
        chk("reset_right", {16'h0, data_right}, 32'h0);
        chk("reset_valid", {31'h0, valid}, 32'h0);
        chk("reset_overrun", {31'h0, overrun}, 32'h0);
        reset = 1'b0;

        // Align past a partial frame, then stream the table back-to-back.
        ready = 1'b1;
        send_word(1'b0, 32'h5, 3);
        send_word(1'b1, 32'h1B, 5);
        for (int i = 0; i < 6; i++) begin
            sb.push_back('{tbl[i].el, tbl[i].er});
            send_word(1'b0, tbl[i].l, tbl[i].n);
            send_word(1'b1, tbl[i].r, tbl[i].n);
        end
        send_slot(1'b0, pend);
        repeat (10) @(posedge clk);
        #1 chk("table_drained", 32'(sb.size()), 32'h0);

        // Handshake: latency, hold while not ready, single-cycle accept.
        do_reset();
        send_slot(1'b1, 1'b0);
        sb.push_back('{16'h3C5A, 16'hC3A5});
        send_word(1'b0, 32'h3C5A, 16);
        send_word(1'b1, 32'hC3A5, 16);
        slot_rise(1'b0, pend);
        repeat (3) @(posedge clk);
        #1 chk("latency_pre", {31'h0, valid}, 32'h0);
        @(posedge clk);
        #1 chk("latency_valid", {31'h0, valid}, 32'h1);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1 chk("hold_valid", {31'h0, valid}, 32'h1);
        end
        chk("hold_left", {16'h0, data_left}, 32'h3C5A);
        chk("hold_right", {16'h0, data_right}, 32'hC3A5);
        ready = 1'b1;
        @(posedge clk);
        #1 ready = 1'b0;
        chk("accept_clears", {31'h0, valid}, 32'h0);
        chk("hs_drained", 32'(sb.size()), 32'h0);

        // Overrun: two frames with no accept.
        do_reset();
        send_slot(1'b1, 1'b0);
        send_word(1'b0, 32'h1234, 16);
        send_word(1'b1, 32'h5678, 16);
        send_word(1'b0, 32'h9ABC, 16);
        send_word(1'b1, 32'hDEF0, 16);
        send_slot(1'b0, pend);
        repeat (6) @(posedge clk);
        #1;
        chk("ovr_valid", {31'h0, valid}, 32'h1);
        chk("ovr_left", {16'h0, data_left}, 32'h9ABC);
        chk("ovr_right", {16'h0, data_right}, 32'hDEF0);
        chk("ovr_flag", {31'h0, overrun}, {31'h0, EXP_OVR});
        sb.push_back('{16'h9ABC, 16'hDEF0});
        ready = 1'b1;
        @(posedge clk);
        #1 ready = 1'b0;
        chk("ovr_accept", {31'h0, valid}, 32'h0);
        chk("ovr_sticky", {31'h0, overrun}, {31'h0, EXP_OVR});
        chk("ovr_drained", 32'(sb.size()), 32'h0);

        // Publish and accept on the same edge.
        do_reset();
        send_slot(1'b1, 1'b0);
        sb.push_back('{16'h1111, 16'h2222});
        sb.push_back('{16'h3333, 16'h4444});
        send_word(1'b0, 32'h1111, 16);
        send_word(1'b1, 32'h2222, 16);
        send_word(1'b0, 32'h3333, 16);
        send_word(1'b1, 32'h4444, 16);
        slot_rise(1'b0, pend);
        repeat (3) @(posedge clk);
        #1 ready = 1'b1;
        chk("sim_pre_valid", {31'h0, valid}, 32'h1);
        chk("sim_pre_left", {16'h0, data_left}, 32'h1111);
        @(posedge clk);
        #1;
        chk("sim_valid", {31'h0, valid}, 32'h1);
        chk("sim_left", {16'h0, data_left}, 32'h3333);
        chk("sim_right", {16'h0, data_right}, 32'h4444);
        chk("sim_overrun", {31'h0, overrun}, 32'h0);
        @(posedge clk);
        #1 ready = 1'b0;
        chk("sim_accept", {31'h0, valid}, 32'h0);
        chk("sim_drained", 32'(sb.size()), 32'h0);

        // Reset in the 8th bit of a right word, then realign.
        do_reset();
        send_slot(1'b1, 1'b0);
        send_word(1'b0, 32'hBEEF, 16);
        send_word(1'b1, 32'h1357, 16);
        send_word(1'b0, 32'h2468, 16);
        w = 16'h7777;
        for (int i = 15; i >= 9; i--) begin
            send_slot(1'b1, pend);
            pend = w[i];
        end
        slot_rise(1'b1, pend);
        chk("pre_reset_left", {16'h0, data_left}, 32'hBEEF);
        @(posedge clk);
        #1 reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("mid_reset_left", {16'h0, data_left}, 32'h0);
        chk("mid_reset_right", {16'h0, data_right}, 32'h0);
        chk("mid_reset_valid", {31'h0, valid}, 32'h0);
        chk("mid_reset_overrun", {31'h0, overrun}, 32'h0);
        reset = 1'b0;
        pend = 1'b0;
        ready = 1'b1;
        send_word(1'b1, 32'h0, 8);
        sb.push_back('{16'hCAFE, 16'hF00D});
        send_word(1'b0, 32'hCAFE, 16);
        send_word(1'b1, 32'hF00D, 16);
        send_slot(1'b0, pend);
        repeat (8) @(posedge clk);
        #1 chk("realign_drained", 32'(sb.size()), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
